fifo_uart_tx: RTL and testbench

- Serial transmit stage that drains the byte FIFO (`FIFO_Memory`) and sends each byte on a single-wire 8N1 UART line.
- Polls the FIFO `empty` flag and issues one-cycle `rd_en` pops.
- Captures the popped byte and shifts it out LSB first at a fixed clocks-per-bit rate.
- Sits directly downstream of the FIFO; the FIFO's `rd_en`, `data_out` and `empty` connect to this block's `fifo_rd_en`, `fifo_data` and `fifo_empty`.

---
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a byte FIFO: polls empty, pops one byte,
// then shifts it out LSB first at CLKS_PER_BIT clocks per bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q,    tx_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q,  done_d;
  logic              bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold it.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
        end
      end

      S_FETCH: state_d = S_LOAD;

      // The FIFO presents the popped byte one cycle after rd_en.
      S_LOAD: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // tx_done is registered, so it is requested one cycle early to land
      // on the final stop-bit cycle.
      S_STOP: begin
        done_d = (cnt_q == CNT_PRE);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign tx_done    = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural FIFO feeds the DUT and each frame is
// compared bit-for-bit against {stop, byte, start} built from a byte queue.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data_out valid the cycle after a pop.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  // Waits up to 'budget' extra cycles for a pop, then checks the whole frame.
  // drop_at >= 0 lowers enable when that frame bit starts.
  task automatic expect_frame(input int budget, input int drop_at, output int pop_cyc);
    logic [DW-1:0] b;
    logic [DW+1:0] frame;
    int waited;
    waited  = 0;
    pop_cyc = -1;
    @(negedge clk);
    while (fifo_rd_en !== 1'b1 && waited < budget) begin
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL idle_tx: got %b expected 1", tx);
      end
      @(negedge clk);
      waited++;
    end
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL pop_timeout: rd_en got %b expected 1 within %0d cycles", fifo_rd_en, budget);
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pop: got pop with model queue empty");
      return;
    end
    pop_cyc = cyc;
    b = exp_q.pop_front();
    frame = {1'b1, b, 1'b0};
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_fetch: got %b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL load_cycle: rd_en=%b tx=%b expected rd_en=0 tx=1", fifo_rd_en, tx);
    end
    for (int i = 0; i < DW + 2; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (i == drop_at && c == 0) enable = 1'b0;
        checks++;
        if (tx !== frame[i]) begin
          errors++;
          $display("FAIL tx_bit: byte %h bit %0d cycle %0d got %b expected %b", b, i, c, tx, frame[i]);
        end
        checks++;
        if (tx_done !== ((i == DW + 1) && (c == CPB - 1))) begin
          errors++;
          $display("FAIL tx_done: bit %0d cycle %0d got %b expected %b", i, c, tx_done,
                   (i == DW + 1) && (c == CPB - 1));
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_ctl: bit %0d rd_en=%b busy=%b expected rd_en=0 busy=1", i, fifo_rd_en, busy);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: busy=%b tx=%b tx_done=%b expected 0,1,0", busy, tx, tx_done);
    end
  endtask

  task automatic idle_window(input int n, input logic exp_empty);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== exp_empty) begin
        errors++;
        $display("FAIL idle: rd_en=%b tx=%b busy=%b empty=%b expected 0,1,0,%b",
                 fifo_rd_en, tx, busy, fifo_empty, exp_empty);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tx=%b rd_en=%b busy=%b done=%b expected 1,0,0,0",
               tx, fifo_rd_en, busy, tx_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    int pc;
    enable = 1'b1;
    push(8'hAA);
    expect_frame(20, -1, pc);
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: got %b expected 1", fifo_empty);
    end
    idle_window(10, 1'b1);
  endtask

  task automatic test_back_to_back();
    int pc0, pc1;
    push(8'hAA);
    push(8'hBF);
    expect_frame(20, -1, pc0);
    expect_frame(20, -1, pc1);
    checks++;
    if (pc1 - pc0 !== (DW + 2) * CPB + 3) begin
      errors++;
      $display("FAIL pop_spacing: got %0d expected %0d", pc1 - pc0, (DW + 2) * CPB + 3);
    end
  endtask

  task automatic test_empty();
    enable = 1'b1;
    idle_window(200, 1'b1);
  endtask

  task automatic test_enable_gating();
    int pc;
    enable = 1'b0;
    push(8'h55);
    idle_window(50, 1'b0);
    enable = 1'b1;
    expect_frame(0, -1, pc);
  endtask

  task automatic test_enable_drop();
    int pc;
    enable = 1'b1;
    push(8'($urandom));
    push(8'($urandom));
    expect_frame(20, 3, pc);
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("FAIL drop_applied: enable got %b expected 0", enable);
    end
    idle_window(60, 1'b0);
    enable = 1'b1;
    expect_frame(0, -1, pc);
  endtask

  task automatic test_random();
    int pc;
    enable = 1'b1;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push(8'($urandom));
      expect_frame(20, -1, pc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    logic [DW-1:0] lost;
    enable = 1'b1;
    push(8'($urandom));
    waited = 0;
    @(negedge clk);
    while (fifo_rd_en !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pop_timeout: rd_en got %b expected 1", fifo_rd_en);
    end
    lost = exp_q.pop_front();
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: got %b expected 1 (byte %h)", busy, lost);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: tx=%b busy=%b rd_en=%b done=%b expected 1,0,0,0",
               tx, busy, fifo_rd_en, tx_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_window(100, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_enable_gating();
    test_enable_drop();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
